// File: rtl/ascon_pkg.sv
// Shared types, round counts and round-constant helper for the Ascon permutation scheduler.
package ascon_pkg;

  localparam int unsigned LANE_W     = 64;
  localparam int unsigned NLANES     = 5;
  localparam int unsigned ROUNDS_PA  = 12;
  localparam int unsigned ROUNDS_PB6 = 6;
  localparam int unsigned ROUNDS_PB8 = 8;

  // Lane 0 is x0 ... lane 4 is x4.
  typedef logic [NLANES-1:0][LANE_W-1:0] ascon_state_t;

  typedef enum logic [1:0] {IDLE, RUN, WB, HOLD} sched_state_e;

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {~r, r};
  endfunction

  function automatic logic legal_rounds(input logic [3:0] n);
    return (n == 4'(ROUNDS_PA)) || (n == 4'(ROUNDS_PB6)) || (n == 4'(ROUNDS_PB8));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant add, 5-bit S-box layer, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t src,
  input  logic [7:0]   rconst,
  output ascon_state_t dst
);

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Bit-sliced S-box applied to all 64 columns in parallel.
  always_comb begin
    x0 = src[0];
    x1 = src[1];
    x2 = src[2] ^ {56'h0, rconst};
    x3 = src[3];
    x4 = src[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    dst[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    dst[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    dst[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    dst[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    dst[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
  end

endmodule

// File: rtl/ascon_perm_sched.sv
// Ascon permutation sequencer: snapshots state, runs 6/8/12 rounds, writes back once.
// Optional cycle counter enabled by defining ASCON_SCHED_PERF_EN.
module ascon_perm_sched
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [3:0]         nrounds_i,
  input  ascon_state_t       state_i,
  output ascon_state_t       state_o,
  output logic               update_state_o,
  output logic               finished_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   perf_cycles_o
);

  sched_state_e state, nxt;
  ascon_state_t state_q;
  logic [3:0]   rcnt;
  logic         load, adv, set_err, last, pulse_d, busy_d;
  ascon_state_t stage [UNROLL+1];

  assign stage[0] = state_q;
  assign state_o  = state_q;

  // UNROLL rounds chained per clock; each copy gets its absolute round's constant.
  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .src    (stage[k]),
      .rconst (rc(rcnt + 4'(k))),
      .dst    (stage[k+1])
    );
  end

  assign last = (5'(rcnt) + 5'(UNROLL)) == 5'(ROUNDS_PA);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt     = state;
    load    = 1'b0;
    adv     = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (legal_rounds(nrounds_i)) begin
            nxt  = RUN;
            load = 1'b1;
          end else begin
            nxt     = HOLD;
            set_err = 1'b1;
          end
        end
      end
      RUN: begin
        adv = 1'b1;
        if (last) nxt = WB;
      end
      WB:      nxt = HOLD;
      HOLD:    if (!start_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    pulse_d = (nxt == WB);
    busy_d  = (nxt == RUN) || (nxt == WB);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= '0;
      rcnt           <= '0;
      err_o          <= 1'b0;
      update_state_o <= 1'b0;
      finished_o     <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      if (load) begin
        state_q <= state_i;
        rcnt    <= 4'(ROUNDS_PA) - nrounds_i;
      end else if (adv) begin
        state_q <= stage[UNROLL];
        rcnt    <= rcnt + 4'(UNROLL);
      end
      if (load)         err_o <= 1'b0;
      else if (set_err) err_o <= 1'b1;
      update_state_o <= pulse_d;
      finished_o     <= pulse_d;
      busy_o         <= busy_d;
    end
  end

`ifdef ASCON_SCHED_PERF_EN
  logic [CNT_W-1:0] cyc, cyc_inc;

  assign cyc_inc = (&cyc) ? cyc : cyc + CNT_W'(1);

  // Counts RUN and WB cycles; the WB cycle itself is included in the published value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc           <= '0;
      perf_cycles_o <= '0;
    end else begin
      if (load)                              cyc <= '0;
      else if ((state == RUN) || (state == WB)) cyc <= cyc_inc;
      if (state == WB) perf_cycles_o <= cyc_inc;
    end
  end
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed + randomized bench for ascon_perm_sched against a table-driven Ascon reference.
module tb_ascon_perm_sched;
  import ascon_pkg::*;

`ifdef ASCON_SCHED_PERF_EN
  localparam int unsigned UNROLL = 2;
`else
  localparam int unsigned UNROLL = 1;
`endif
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       nrounds;
  ascon_state_t     state_in, state_out;
  logic             update, finished, busy, err;
  logic [CNT_W-1:0] perf;

  int vecs = 0;
  int miss = 0;

  ascon_perm_sched #(.UNROLL(UNROLL), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .nrounds_i      (nrounds),
    .state_i        (state_in),
    .state_o        (state_out),
    .update_state_o (update),
    .finished_o     (finished),
    .busy_o         (busy),
    .err_o          (err),
    .perf_cycles_o  (perf)
  );

  always #5 clk = ~clk;

  // Ascon S-box as a lookup table, input/output bit 4 = x0 ... bit 0 = x4.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  // Last n rounds of p12, applied column by column through the S-box table.
  function automatic ascon_state_t ref_perm(input ascon_state_t s, input int n);
    logic [63:0]  x [5];
    logic [4:0]   col, o;
    logic [3:0]   rr;
    ascon_state_t res;
    for (int i = 0; i < 5; i++) x[i] = s[i];
    for (int r = 12 - n; r < 12; r++) begin
      rr = 4'(r);
      x[2][7:0] = x[2][7:0] ^ {~rr, rr};
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = SBOX[col];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      x[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
      x[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
      x[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
      x[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
      x[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
    end
    for (int i = 0; i < 5; i++) res[i] = x[i];
    return res;
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] exp_perf(input int n);
`ifdef ASCON_SCHED_PERF_EN
    return CNT_W'(n / UNROLL + 1);
`else
    return CNT_W'(0 * n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One full permutation; start is left high on return (HOLD).
  task automatic do_run(input string tag, input ascon_state_t s, input int n);
    ascon_state_t exp;
    int           edges;
    bit           seen;
    exp = ref_perm(s, n);
    @(negedge clk);
    start = 1'b1; nrounds = 4'(n); state_in = s;
    @(posedge clk);
    #1;
    chk({tag, "_err_clr"}, 320'(err), 320'(0));
    chk({tag, "_busy"},    320'(busy), 320'(1));
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      state_in = rand_state();
      nrounds  = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      edges++;
      if (finished) seen = 1'b1;
    end
    chk({tag, "_done"},    320'(seen), 320'(1));
    chk({tag, "_latency"}, 320'(edges), 320'(n / UNROLL));
    chk({tag, "_update"},  320'(update), 320'(1));
    chk({tag, "_state"},   state_out, exp);
    @(posedge clk);
    #1;
    chk({tag, "_fin_1cyc"}, 320'(finished), 320'(0));
    chk({tag, "_upd_1cyc"}, 320'(update), 320'(0));
    chk({tag, "_idle_busy"}, 320'(busy), 320'(0));
    chk({tag, "_perf"},     320'(perf), 320'(exp_perf(n)));
  endtask

  initial begin
    ascon_state_t iv_state;
    int           n;
    int           pulses;

    rst_n = 1'b0; start = 1'b0; nrounds = 4'd0; state_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   320'(busy), 320'(0));
    chk("rst_update", 320'(update), 320'(0));
    chk("rst_fin",    320'(finished), 320'(0));
    chk("rst_err",    320'(err), 320'(0));
    chk("rst_state",  state_out, 320'(0));
    chk("rst_perf",   320'(perf), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // p12 of the all-zero state
    do_run("p12_zero", '0, 12);
    drop_start();

    // Ascon-128 initial state: IV, key, nonce
    iv_state[0] = 64'h80400c0600000000;
    iv_state[1] = 64'h0001020304050607;
    iv_state[2] = 64'h08090a0b0c0d0e0f;
    iv_state[3] = 64'h0011223344556677;
    iv_state[4] = 64'h8899aabbccddeeff;
    do_run("p6_iv", iv_state, 6);
    drop_start();
    do_run("p8_iv", iv_state, 8);
    drop_start();

    // Illegal round count goes to HOLD with the sticky error
    @(negedge clk);
    start = 1'b1; nrounds = 4'd5; state_in = rand_state();
    @(posedge clk);
    #1;
    chk("bad_err",  320'(err), 320'(1));
    chk("bad_busy", 320'(busy), 320'(0));
    pulses = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      pulses += int'(update) + int'(finished);
    end
    chk("bad_no_pulse", 320'(pulses), 320'(0));
    chk("bad_err_sticky", 320'(err), 320'(1));
    drop_start();
    chk("bad_err_kept", 320'(err), 320'(1));
    do_run("after_bad", rand_state(), 12);

    // Start kept high after completion must not re-trigger
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      pulses += int'(update) + int'(busy);
    end
    chk("hold_no_rerun", 320'(pulses), 320'(0));
    drop_start();
    do_run("rearm", rand_state(), 8);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      pulses += int'(update);
    end
    chk("rearm_once", 320'(pulses), 320'(0));
    drop_start();

    // Reset in the middle of a 12-round run
    @(negedge clk);
    start = 1'b1; nrounds = 4'd12; state_in = rand_state();
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   320'(busy), 320'(0));
    chk("midrst_update", 320'(update), 320'(0));
    chk("midrst_state",  state_out, 320'(0));
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      pulses += int'(update) + int'(finished) + int'(busy);
    end
    chk("midrst_quiet", 320'(pulses), 320'(0));
    do_run("post_rst", rand_state(), 12);
    drop_start();

    // Randomized legal runs
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       n = 6;
        1:       n = 8;
        default: n = 12;
      endcase
      do_run($sformatf("rand%0d_n%0d", i, n), rand_state(), n);
      drop_start();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
